ssp_tx_serializer: RTL

Transmit parallel-to-serial stage of the SSP, directly downstream of the transmit FIFO.
- Pops words from the TX FIFO and generates SSPCLKOUT at PCLK/2.
- Emits each word as a framed serial stream: one-SSPCLKOUT-period SSPFSSOUT pulse, then data, MSB first by default.
- Drives SSPTXD, SSPFSSOUT and SSPOE_B at the SSP pins; supports back-to-back frames while the FIFO is non-empty.

---
 rtl/ssp_tx_serializer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ssp_tx_serializer.sv
// rtl/ssp_tx_serializer.sv - SSP transmit serializer: FIFO pop, PCLK/2 serial clock, framed serial output.
// Define SSP_TX_LSB_FIRST_EN to transmit LSB first; the default build is MSB first.
module ssp_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  CLEAR_B,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_EMPTY,
    output logic                  TX_POP,
    output logic                  SSPCLKOUT,
    output logic                  SSPFSSOUT,
    output logic                  SSPTXD,
    output logic                  SSPOE_B,
    output logic                  TX_BUSY
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SYNC, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  sclk_q, sclk_d;
    logic                  fss_q, fss_d;
    logic                  txd_q, txd_d;
    logic                  oe_b_q, oe_b_d;
    logic                  pop_q, pop_d;
    logic                  busy_q, busy_d;

    logic                  out_bit;
    logic [DATA_WIDTH-1:0] shreg_next;

`ifdef SSP_TX_LSB_FIRST_EN
    assign out_bit    = shreg_q[0];
    assign shreg_next = {1'b0, shreg_q[DATA_WIDTH-1:1]};
`else
    assign out_bit    = shreg_q[DATA_WIDTH-1];
    assign shreg_next = {shreg_q[DATA_WIDTH-2:0], 1'b0};
`endif

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            fss_q   <= 1'b0;
            txd_q   <= 1'b0;
            oe_b_q  <= 1'b1;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            fss_q   <= fss_d;
            txd_q   <= txd_d;
            oe_b_q  <= oe_b_d;
            pop_q   <= pop_d;
            busy_q  <= busy_d;
        end
    end

    // Everything except the clock and the pop strobe moves only on a rise edge (sclk_q currently 0).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        sclk_d  = ~sclk_q;
        fss_d   = fss_q;
        txd_d   = txd_q;
        oe_b_d  = oe_b_q;
        pop_d   = 1'b0;
        busy_d  = busy_q;
        if (!sclk_q) begin
            case (state_q)
                IDLE: begin
                    if (!TX_EMPTY) begin
                        shreg_d = TX_DATA;
                        fss_d   = 1'b1;
                        oe_b_d  = 1'b0;
                        txd_d   = 1'b0;
                        busy_d  = 1'b1;
                        pop_d   = 1'b1;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    fss_d   = 1'b0;
                    txd_d   = out_bit;
                    shreg_d = shreg_next;
                    cnt_d   = CNT_LAST;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        // Last bit has been held a full period with nothing queued behind it.
                        oe_b_d  = 1'b1;
                        txd_d   = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        txd_d   = out_bit;
                        shreg_d = shreg_next;
                        cnt_d   = cnt_q - CW'(1);
                        // Back-to-back: the next frame's sync overlaps this last bit.
                        if (cnt_q == CW'(1) && !TX_EMPTY) begin
                            fss_d   = 1'b1;
                            shreg_d = TX_DATA;
                            pop_d   = 1'b1;
                            cnt_d   = CNT_LAST;
                            state_d = SYNC;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign TX_POP    = pop_q;
    assign SSPCLKOUT = sclk_q;
    assign SSPFSSOUT = fss_q;
    assign SSPTXD    = txd_q;
    assign SSPOE_B   = oe_b_q;
    assign TX_BUSY   = busy_q;

endmodule
